// File: rtl/bram_port_arbiter.sv
// Two-requester arbiter for BRAM port B.
// Requester 0 (CPU data) and requester 1 (DMA/debug) share one port.
// Ties go round-robin. A locked requester can keep ownership for a burst,
// but it is preempted after MAX_HOLD grants if the other side is waiting.
module bram_port_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_HOLD = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic              i_lock0,
    input  logic              i_lock1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata0,
    output logic [DATA_W-1:0] o_rdata1,
    output logic              o_bram_we,
    output logic [ADDR_W-1:0] o_bram_addr,
    output logic [DATA_W-1:0] o_bram_di,
    input  logic [DATA_W-1:0] i_bram_do,
    output logic [1:0]        o_owner
);

    localparam int HOLD_W = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t            state;
    logic              last;      // index of the requester served most recently
    logic [HOLD_W-1:0] hold;
    logic              rd_pend0;
    logic              rd_pend1;

    // Read data comes straight from the BRAM; o_rvalidN marks whose it is.
    assign o_rdata0 = i_bram_do;
    assign o_rdata1 = i_bram_do;

    // Grant decision: round-robin in IDLE, owner only while locked.
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (i_rst) begin
            case (state)
                IDLE: begin
                    if (i_req0 && i_req1) begin
                        o_gnt0 = last;
                        o_gnt1 = ~last;
                    end else begin
                        o_gnt0 = i_req0;
                        o_gnt1 = i_req1;
                    end
                end
                OWN0:    o_gnt0 = i_req0 && i_lock0 && !(hold == HOLD_MAX && i_req1);
                OWN1:    o_gnt1 = i_req1 && i_lock1 && !(hold == HOLD_MAX && i_req0);
                default: ;
            endcase
        end
    end

    // Ownership state, last-served pointer, hold counter and owner flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            last    <= 1'b1;
            hold    <= '0;
            o_owner <= 2'b00;
        end else begin
            if (o_gnt0) begin
                last <= 1'b0;
            end else if (o_gnt1) begin
                last <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (o_gnt0 && i_lock0) begin
                        state   <= OWN0;
                        hold    <= HOLD_W'(1);
                        o_owner <= 2'b01;
                    end else if (o_gnt1 && i_lock1) begin
                        state   <= OWN1;
                        hold    <= HOLD_W'(1);
                        o_owner <= 2'b10;
                    end else begin
                        hold <= '0;
                    end
                end
                OWN0: begin
                    if (o_gnt0) begin
                        if (hold != HOLD_MAX) hold <= hold + HOLD_W'(1);
                    end else begin
                        // Preemption leaves the pointer at 0 so requester 1 wins the next tie.
                        state   <= IDLE;
                        hold    <= '0;
                        o_owner <= 2'b00;
                        last    <= 1'b0;
                    end
                end
                OWN1: begin
                    if (o_gnt1) begin
                        if (hold != HOLD_MAX) hold <= hold + HOLD_W'(1);
                    end else begin
                        state   <= IDLE;
                        hold    <= '0;
                        o_owner <= 2'b00;
                        last    <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    hold    <= '0;
                    o_owner <= 2'b00;
                end
            endcase
        end
    end

    // BRAM command register and two-stage read-valid pipeline.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_bram_we   <= 1'b0;
            o_bram_addr <= '0;
            o_bram_di   <= '0;
            rd_pend0    <= 1'b0;
            rd_pend1    <= 1'b0;
            o_rvalid0   <= 1'b0;
            o_rvalid1   <= 1'b0;
        end else begin
            rd_pend0  <= o_gnt0 & ~i_we0;
            rd_pend1  <= o_gnt1 & ~i_we1;
            o_rvalid0 <= rd_pend0;
            o_rvalid1 <= rd_pend1;
            if (o_gnt0) begin
                o_bram_we   <= i_we0;
                o_bram_addr <= i_addr0;
                o_bram_di   <= i_wdata0;
            end else if (o_gnt1) begin
                o_bram_we   <= i_we1;
                o_bram_addr <= i_addr1;
                o_bram_di   <= i_wdata1;
            end else begin
                o_bram_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed testbench for bram_port_arbiter with a behavioural BRAM port B.
// Memory is preloaded with mem[a] = a[7:0] ^ 8'h3C.
module tb_bram_port_arbiter;

    logic        i_clk;
    logic        i_rst;
    logic        i_req0, i_req1, i_we0, i_we1, i_lock0, i_lock1;
    logic [15:0] i_addr0, i_addr1;
    logic [7:0]  i_wdata0, i_wdata1;
    logic        o_gnt0, o_gnt1, o_rvalid0, o_rvalid1, o_bram_we;
    logic [7:0]  o_rdata0, o_rdata1, o_bram_di, i_bram_do;
    logic [15:0] o_bram_addr;
    logic [1:0]  o_owner;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:65535];

    bram_port_arbiter #(.ADDR_W(16), .DATA_W(8), .MAX_HOLD(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_req1(i_req1), .i_we0(i_we0), .i_we1(i_we1),
        .i_addr0(i_addr0), .i_addr1(i_addr1),
        .i_wdata0(i_wdata0), .i_wdata1(i_wdata1),
        .i_lock0(i_lock0), .i_lock1(i_lock1),
        .o_gnt0(o_gnt0), .o_gnt1(o_gnt1),
        .o_rvalid0(o_rvalid0), .o_rvalid1(o_rvalid1),
        .o_rdata0(o_rdata0), .o_rdata1(o_rdata1),
        .o_bram_we(o_bram_we), .o_bram_addr(o_bram_addr), .o_bram_di(o_bram_di),
        .i_bram_do(i_bram_do), .o_owner(o_owner)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Read-first synchronous BRAM port
    always @(posedge i_clk) begin
        if (o_bram_we) mem[o_bram_addr] <= o_bram_di;
        i_bram_do <= mem[o_bram_addr];
    end

    typedef struct {
        logic        req0, req1, we0, we1;
        logic [15:0] addr0, addr1;
        logic [7:0]  wdata0, wdata1;
        logic        gnt0, gnt1, bram_we;
        logic [15:0] bram_addr;
        logic [7:0]  bram_di;
        logic        rvalid0, rvalid1;
        logic [7:0]  rdata0, rdata1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic r0, input logic r1, input logic w0, input logic w1,
        input logic [15:0] a0, input logic [15:0] a1,
        input logic [7:0] d0, input logic [7:0] d1,
        input logic g0, input logic g1, input logic bwe,
        input logic [15:0] baddr, input logic [7:0] bdi,
        input logic rv0, input logic rv1,
        input logic [7:0] rd0, input logic [7:0] rd1);
        vec_t v;
        v.req0 = r0; v.req1 = r1; v.we0 = w0; v.we1 = w1;
        v.addr0 = a0; v.addr1 = a1; v.wdata0 = d0; v.wdata1 = d1;
        v.gnt0 = g0; v.gnt1 = g1; v.bram_we = bwe; v.bram_addr = baddr; v.bram_di = bdi;
        v.rvalid0 = rv0; v.rvalid1 = rv1; v.rdata0 = rd0; v.rdata1 = rd1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r0, input logic r1, input logic w0, input logic w1,
                         input logic l0, input logic l1,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        i_req0 = r0; i_req1 = r1; i_we0 = w0; i_we1 = w1;
        i_lock0 = l0; i_lock1 = l1;
        i_addr0 = a0; i_addr1 = a1; i_wdata0 = d0; i_wdata1 = d1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_gnt0"},    32'(o_gnt0), 32'd0);
        chk({tag, "_gnt1"},    32'(o_gnt1), 32'd0);
        chk({tag, "_we"},      32'(o_bram_we), 32'd0);
        chk({tag, "_addr"},    32'(o_bram_addr), 32'd0);
        chk({tag, "_di"},      32'(o_bram_di), 32'd0);
        chk({tag, "_rvalid0"}, 32'(o_rvalid0), 32'd0);
        chk({tag, "_rvalid1"}, 32'(o_rvalid1), 32'd0);
        chk({tag, "_owner"},   32'(o_owner), 32'd0);
    endtask

    // Called 1 ns after a rising edge: half-cycle low pulse with both requests up.
    task automatic pulse_reset(input string tag);
        #2;
        i_rst = 1'b0;
        drive(1, 1, 0, 0, 1, 1, 16'h2222, 16'h3333, 8'h00, 8'h00);
        #1;
        check_reset_vals(tag);
        #4;
        i_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00);
    endtask

    int ngrants;
    logic [5:0] exp_g037;

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'(a) ^ 8'h3C;

        // Reset held with both requesters asking: nothing may be granted.
        i_rst = 1'b0;
        drive(1, 1, 0, 0, 1, 1, 16'h1111, 16'h2222, 8'h55, 8'h66);
        #2;
        check_reset_vals("async_rst");
        @(negedge i_clk);
        check_reset_vals("held_rst");
        @(negedge i_clk);
        i_rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00);

        // Tie, round-robin, write-then-read and a 10-cycle idle stretch
        vecs.push_back(mk(1,1,0,0,16'h1234,16'h0010,8'h00,8'h00, 1,0,0,16'h0000,8'h00,0,0,8'h00,8'h00));
        vecs.push_back(mk(1,1,0,0,16'h1234,16'h0010,8'h00,8'h00, 0,1,0,16'h1234,8'h00,0,0,8'h00,8'h00));
        vecs.push_back(mk(0,0,0,0,16'h1234,16'h0010,8'h00,8'h00, 0,0,0,16'h0010,8'h00,1,0,8'h08,8'h00));
        vecs.push_back(mk(0,0,0,0,16'h1234,16'h0010,8'h00,8'h00, 0,0,0,16'h0010,8'h00,0,1,8'h00,8'h2C));
        vecs.push_back(mk(0,1,0,1,16'hBEEF,16'h00FF,8'h00,8'hA5, 0,1,0,16'h0010,8'h00,0,0,8'h00,8'h00));
        vecs.push_back(mk(0,1,0,0,16'hBEEF,16'h00FF,8'h00,8'h00, 0,1,1,16'h00FF,8'hA5,0,0,8'h00,8'h00));
        vecs.push_back(mk(0,0,0,0,16'hBEEF,16'hCAFE,8'h00,8'h00, 0,0,0,16'h00FF,8'h00,0,0,8'h00,8'h00));
        vecs.push_back(mk(0,0,0,0,16'hBEEF,16'hCAFE,8'h00,8'h00, 0,0,0,16'h00FF,8'h00,0,1,8'h00,8'hA5));
        for (int n = 0; n < 10; n++)
            vecs.push_back(mk(0,0,1,1,16'hBEEF,16'hCAFE,8'h77,8'h88, 0,0,0,16'h00FF,8'h00,0,0,8'h00,8'h00));

        foreach (vecs[i]) begin
            @(posedge i_clk); #1;
            drive(vecs[i].req0, vecs[i].req1, vecs[i].we0, vecs[i].we1, 0, 0,
                  vecs[i].addr0, vecs[i].addr1, vecs[i].wdata0, vecs[i].wdata1);
            @(negedge i_clk);
            chk($sformatf("v%0d_gnt0", i),    32'(o_gnt0),      32'(vecs[i].gnt0));
            chk($sformatf("v%0d_gnt1", i),    32'(o_gnt1),      32'(vecs[i].gnt1));
            chk($sformatf("v%0d_we", i),      32'(o_bram_we),   32'(vecs[i].bram_we));
            chk($sformatf("v%0d_addr", i),    32'(o_bram_addr), 32'(vecs[i].bram_addr));
            chk($sformatf("v%0d_di", i),      32'(o_bram_di),   32'(vecs[i].bram_di));
            chk($sformatf("v%0d_rvalid0", i), 32'(o_rvalid0),   32'(vecs[i].rvalid0));
            chk($sformatf("v%0d_rvalid1", i), 32'(o_rvalid1),   32'(vecs[i].rvalid1));
            chk($sformatf("v%0d_owner", i),   32'(o_owner),     32'd0);
            if (vecs[i].rvalid0) chk($sformatf("v%0d_rdata0", i), 32'(o_rdata0), 32'(vecs[i].rdata0));
            if (vecs[i].rvalid1) chk($sformatf("v%0d_rdata1", i), 32'(o_rdata1), 32'(vecs[i].rdata1));
        end

        // Locked burst by requester 0, requester 1 waiting from cycle 2: preempt after 8 grants.
        ngrants = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge i_clk); #1;
            drive(1, k >= 2, 0, 0, 1, 0, 16'(k), 16'h0777, 8'h00, 8'h00);
            @(negedge i_clk);
            chk($sformatf("lk%0d_gnt0", k),  32'(o_gnt0), 32'(k < 8));
            chk($sformatf("lk%0d_gnt1", k),  32'(o_gnt1), 32'(k == 9));
            chk($sformatf("lk%0d_owner", k), 32'(o_owner), (k >= 1 && k <= 8) ? 32'd1 : 32'd0);
            chk($sformatf("lk%0d_rvalid0", k), 32'(o_rvalid0), 32'(k >= 2));
            if (k >= 2) chk($sformatf("lk%0d_rdata0", k), 32'(o_rdata0), 32'(8'(k - 2) ^ 8'h3C));
            if (k >= 1 && k <= 8) chk($sformatf("lk%0d_addr", k), 32'(o_bram_addr), 32'(k - 1));
            if (o_gnt0) ngrants++;
        end
        chk("lk_grant_count", 32'(ngrants), 32'd8);
        @(posedge i_clk); #1;
        drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00);
        @(negedge i_clk);
        chk("lk_after_owner", 32'(o_owner), 32'd0);
        chk("lk_after_addr", 32'(o_bram_addr), 32'h0777);
        chk("lk_after_rvalid1_early", 32'(o_rvalid1), 32'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("lk_after_rvalid1", 32'(o_rvalid1), 32'd1);
        chk("lk_after_rdata1", 32'(o_rdata1), 32'h4B);

        // Lock dropped after 3 grants with requester 1 idle.
        exp_g037 = 6'b010111;
        for (int k = 0; k < 6; k++) begin
            @(posedge i_clk); #1;
            drive(k <= 4, 0, 0, 0, k <= 2, 0, 16'h0100 + 16'(k), 16'h0000, 8'h00, 8'h00);
            @(negedge i_clk);
            chk($sformatf("ul%0d_gnt0", k),  32'(o_gnt0), 32'(exp_g037[k]));
            chk($sformatf("ul%0d_gnt1", k),  32'(o_gnt1), 32'd0);
            chk($sformatf("ul%0d_owner", k), 32'(o_owner), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
        end

        // Read granted, then reset pulse before its data slot: no rvalid.
        @(posedge i_clk); #1;
        drive(1, 0, 0, 0, 0, 0, 16'h1234, 16'h0000, 8'h00, 8'h00);
        @(negedge i_clk);
        chk("rr_gnt0", 32'(o_gnt0), 32'd1);
        @(posedge i_clk); #1;
        drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00);
        chk("rr_addr_pre", 32'(o_bram_addr), 32'h1234);
        pulse_reset("rr_pulse");
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            chk($sformatf("rr_rvalid0_%0d", k), 32'(o_rvalid0), 32'd0);
            chk($sformatf("rr_rvalid1_%0d", k), 32'(o_rvalid1), 32'd0);
            @(posedge i_clk); #1;
        end

        // Write registered but not yet performed is dropped by reset.
        drive(0, 1, 0, 1, 0, 0, 16'h0000, 16'h0040, 8'h00, 8'h99);
        @(negedge i_clk);
        chk("wd_gnt1", 32'(o_gnt1), 32'd1);
        @(posedge i_clk); #1;
        drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00);
        chk("wd_we_pending", 32'(o_bram_we), 32'd1);
        pulse_reset("wd_pulse");
        @(posedge i_clk); #1;
        drive(1, 0, 0, 0, 0, 0, 16'h0040, 16'h0000, 8'h00, 8'h00);
        @(negedge i_clk);
        chk("wd_first_gnt0", 32'(o_gnt0), 32'd1);
        @(posedge i_clk); #1;
        drive(0, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 8'h00);
        @(negedge i_clk);
        chk("wd_rvalid0_early", 32'(o_rvalid0), 32'd0);
        @(posedge i_clk); #1;
        @(negedge i_clk);
        chk("wd_rvalid0", 32'(o_rvalid0), 32'd1);
        chk("wd_rdata0", 32'(o_rdata0), 32'h7C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 16, BRAM address width; DATA_W, default 8, BRAM data width; MAX_HOLD, default 8, maximum consecutive locked grants while the other side waits.
REQ-002 Port i_clk SHALL be: input, 1 bit, sole clock, rising edge.
REQ-003 Port i_rst SHALL be: input, 1 bit, reset, asynchronous, active-low.
REQ-004 Ports i_req0 / i_req1 SHALL be: input, 1 bit, access request from requester 0 (CPU data) / 1 (DMA/debug).
REQ-005 Ports i_we0 / i_we1 SHALL be: input, 1 bit, 1 = write, 0 = read.
REQ-006 Ports i_addr0 / i_addr1 SHALL be: input, ADDR_W bits, access address.
REQ-007 Ports i_wdata0 / i_wdata1 SHALL be: input, DATA_W bits, write data.
REQ-008 Ports i_lock0 / i_lock1 SHALL be: input, 1 bit, keep ownership after grant (burst).
REQ-009 Ports o_gnt0 / o_gnt1 SHALL be: output, 1 bit, combinational, request accepted this cycle.
REQ-010 Ports o_rvalid0 / o_rvalid1 SHALL be: output, 1 bit, registered, read data valid.
REQ-011 Ports o_rdata0 / o_rdata1 SHALL be: output, DATA_W bits, equal to i_bram_do.
REQ-012 Port o_bram_we SHALL be: output, 1 bit, registered, BRAM port B write enable.
REQ-013 Ports o_bram_addr / o_bram_di SHALL be: output, ADDR_W / DATA_W bits, registered, BRAM port B address / write data.
REQ-014 Port i_bram_do SHALL be: input, DATA_W bits, BRAM port B read data, valid one cycle after the address is sampled.
REQ-015 Port o_owner SHALL be: output, 2 bits, 00 = none, 01 = requester 0 locked, 10 = requester 1 locked.

Function
REQ-016 State machine SHALL have states IDLE, OWN0 and OWN1, plus a 1-bit last-served pointer and a hold counter.
REQ-017 At most one of o_gnt0 / o_gnt1 SHALL be high in any cycle, and a grant SHALL require the matching i_reqN = 1.
REQ-018 IDLE arbitration: a single requester is granted; with both requesting, the requester not last served is granted (round-robin).
REQ-019 A grant with i_lockN = 1 SHALL move the machine IDLE -> OWNn at the edge, with hold counter = 1.
REQ-020 In OWNn, only requester n SHALL be grantable, and each grant increments the hold counter, saturating at MAX_HOLD.
REQ-021 OWNn SHALL return to IDLE at the edge when i_reqN = 0 or i_lockN = 0, with no grant that cycle.
REQ-022 OWNn SHALL also return to IDLE when hold counter = MAX_HOLD and the other i_req is high.
  - The pointer is then set so the other requester wins the next tie.
  - Requester n receives no grant in that cycle.
REQ-023 Grant timing: a grant in cycle C SHALL update the registered outputs at the end of C.
  - o_bram_addr / o_bram_di take the granted address / data, valid in C+1.
  - o_bram_we equals the granted i_weN.
REQ-024 Cycles with no grant SHALL drive o_bram_we = 0 for the following cycle; o_bram_addr / o_bram_di hold their values.
REQ-025 Read grant to N in cycle C SHALL assert o_rvalidN for exactly cycle C+2, where o_rdataN = i_bram_do.
REQ-026 Write grants SHALL produce no o_rvalid.
REQ-027 Back-to-back grants SHALL sustain one access per cycle, and rvalid ordering SHALL match grant order.
REQ-028 Simultaneous lock requests from IDLE SHALL be resolved by round-robin; the loser waits, with no grant.
REQ-029 The last-served pointer SHALL update on every grant to the granted index.
REQ-030 The hold counter SHALL clear on entry to IDLE.

Reset
REQ-031 While i_rst = 0, independent of i_clk, the following SHALL apply:
  - state IDLE, pointer = 1 (requester 0 wins the first tie), hold counter = 0;
  - o_bram_we = 0, o_bram_addr = 0, o_bram_di = 0;
  - o_rvalid0 = o_rvalid1 = 0, o_owner = 00;
  - o_gnt0 = o_gnt1 = 0.
REQ-032 Reset mid-operation SHALL flush the rvalid pipeline.
  - No o_rvalid SHALL appear for reads granted before reset.
  - A write registered but not yet performed SHALL be dropped (o_bram_we forced 0).
REQ-033 The first grant SHALL be possible in the first cycle after i_rst rises.

Verification
REQ-034 Scenario: out of reset, both requesters read simultaneously, addr0 = 0x1234, addr1 = 0x0010.
  - o_gnt0 in C0, then o_gnt1 in C1.
  - o_bram_addr = 0x1234 in C1, then 0x0010 in C2.
  - o_rvalid0 in C2, o_rvalid1 in C3.
REQ-035 Scenario: requester 1 writes 0xA5 to 0x00FF, then reads 0x00FF.
  - o_bram_we = 1 for one cycle only.
  - Read returns o_rdata1 = 0xA5 with o_rvalid1 exactly 2 cycles after its grant.
REQ-036 Scenario: requester 0 holds lock with continuous reads; requester 1 requests from cycle 2.
  - Exactly 8 grants to requester 0.
  - One idle-transition cycle, then requester 1 is granted.
  - o_owner goes 01 -> 00.
REQ-037 Scenario: requester 0 holds lock and drops i_lock0 after 3 grants while requester 1 is idle.
  - State returns to IDLE and o_owner = 00.
  - The next i_req0 is granted in IDLE.
REQ-038 Scenario: read granted, i_rst pulsed low for a half cycle before C+2.
  - o_rvalid never asserts.
  - All outputs read their reset values during reset.
REQ-039 Scenario: no requests for 10 cycles.
  - o_gnt0 = o_gnt1 = 0 and o_bram_we = 0 throughout.
  - o_bram_addr holds its last value.
